disp_scan_mux: RTL and testbench

//  Time-multiplexed 7-seg digit scanner for the ALU lab datapath. Selects operands or result by the
//  one-hot op code. Drives one active-low anode at a time plus the 4-bit hex nibble for that digit.

---
 rtl/disp_pkg.sv | 24 ++
 rtl/disp_prescaler.sv | 34 +++
 rtl/disp_scan_mux.sv | 141 ++++++++++++++
 tb/tb_disp_scan_mux.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared types, op encodings and mode decode for the 7-seg scan multiplexer.
package disp_pkg;

  typedef enum logic [1:0] {
    MODE_OPERANDS,
    MODE_RESULT,
    MODE_BLANK
  } disp_mode_e;

  localparam logic [3:0] OP_RES0 = 4'b1000;
  localparam logic [3:0] OP_RES1 = 4'b0100;
  localparam logic [3:0] OP_BLK0 = 4'b0010;
  localparam logic [3:0] OP_BLK1 = 4'b0001;

  // Anything that is not one of the four recognised codes (zero, multi-hot) shows the operands.
  function automatic disp_mode_e decode_mode(input logic [3:0] op);
    case (op)
      OP_RES0, OP_RES1: return MODE_RESULT;
      OP_BLK0, OP_BLK1: return MODE_BLANK;
      default:          return MODE_OPERANDS;
    endcase
  endfunction

endpackage

// File: rtl/disp_prescaler.sv
// Modulo-REFRESH_DIV counter; slot_tick is high during the terminal count cycle.
module disp_prescaler
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic clk,
  input  logic reset_n,
  output logic slot_tick
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  generate
    if (REFRESH_DIV < 2) begin : g_bad_div
      $fatal(1, "disp_prescaler: REFRESH_DIV must be >= 2");
    end
  endgenerate

  logic [CW-1:0] cnt_reg;

  assign slot_tick = (cnt_reg == CW'(REFRESH_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else if (slot_tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/disp_scan_mux.sv
// Time-multiplexed 7-seg scanner with once-per-frame input snapshot.
// Optional build macro LEADING_ZERO_BLANK_EN darkens leading zero nibbles of each field.
module disp_scan_mux
  import disp_pkg::*;
#(
  parameter int N_DIGITS    = 8,
  parameter int DATA_W      = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [3:0]                  op,
  input  logic [DATA_W-1:0]           A,
  input  logic [DATA_W-1:0]           B,
  input  logic [DATA_W-1:0]           res,
  output logic [N_DIGITS-1:0]         anodo,
  output logic [3:0]                  digit,
  output logic [$clog2(N_DIGITS)-1:0] dig_idx,
  output logic                        frame_tick
);

  localparam int NF    = DATA_W / 4;
  localparam int IDX_W = $clog2(N_DIGITS);

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  generate
    if (N_DIGITS < DATA_W / 2 || DATA_W % 4 != 0) begin : g_bad_params
      $fatal(1, "disp_scan_mux: need DATA_W%%4==0 and N_DIGITS >= DATA_W/2");
    end
  endgenerate

  logic slot_tick;
  logic frame_edge;

  disp_prescaler #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_prescaler (
    .clk      (clk),
    .reset_n  (reset_n),
    .slot_tick(slot_tick)
  );

  logic [IDX_W-1:0]    dig_idx_reg, dig_idx_next;
  logic [3:0]          shadow_op_reg, shadow_op_next;
  logic [DATA_W-1:0]   shadow_a_reg, shadow_a_next;
  logic [DATA_W-1:0]   shadow_b_reg, shadow_b_next;
  logic [DATA_W-1:0]   shadow_res_reg, shadow_res_next;
  logic [N_DIGITS-1:0] anodo_reg, anodo_next;
  logic [3:0]          digit_reg, digit_next;
  logic                frame_tick_reg;
  disp_mode_e          mode;

  logic [N_DIGITS-1:0]      slot_lit;
  logic [N_DIGITS-1:0][3:0] slot_nib;

  assign frame_edge = slot_tick && (dig_idx_reg == IDX_W'(N_DIGITS - 1));

  always_comb begin
    dig_idx_next    = dig_idx_reg;
    shadow_op_next  = shadow_op_reg;
    shadow_a_next   = shadow_a_reg;
    shadow_b_next   = shadow_b_reg;
    shadow_res_next = shadow_res_reg;
    if (slot_tick) begin
      dig_idx_next = frame_edge ? '0 : dig_idx_reg + 1'b1;
    end
    if (frame_edge) begin
      shadow_op_next  = op;
      shadow_a_next   = A;
      shadow_b_next   = B;
      shadow_res_next = res;
    end
  end

  // Outputs are computed from the post-edge index and snapshot so slot 0 of a new frame shows new data.
  assign mode = decode_mode(shadow_op_next);

  generate
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_slot
      if (gi < NF) begin : g_low
        logic a_show, r_show;
        assign a_show = !LZB || (gi == 0) || (|shadow_a_next[DATA_W-1:4*gi]);
        assign r_show = !LZB || (gi == 0) || (|shadow_res_next[DATA_W-1:4*gi]);
        assign slot_nib[gi] = (mode == MODE_RESULT) ? shadow_res_next[4*gi+:4]
                                                    : shadow_a_next[4*gi+:4];
        assign slot_lit[gi] = (mode == MODE_RESULT)   ? r_show :
                              (mode == MODE_OPERANDS) ? a_show : 1'b0;
      end else if (gi < 2 * NF) begin : g_high
        logic b_show;
        assign b_show = !LZB || (gi == NF) || (|shadow_b_next[DATA_W-1:4*(gi-NF)]);
        assign slot_nib[gi] = shadow_b_next[4*(gi-NF)+:4];
        assign slot_lit[gi] = (mode == MODE_OPERANDS) && b_show;
      end else begin : g_dark
        assign slot_nib[gi] = 4'h0;
        assign slot_lit[gi] = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    anodo_next = '1;
    digit_next = 4'h0;
    if (slot_lit[dig_idx_next]) begin
      anodo_next = ~(N_DIGITS'(1) << dig_idx_next);
      digit_next = slot_nib[dig_idx_next];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dig_idx_reg    <= '0;
      shadow_op_reg  <= '0;
      shadow_a_reg   <= '0;
      shadow_b_reg   <= '0;
      shadow_res_reg <= '0;
      anodo_reg      <= '1;
      digit_reg      <= 4'h0;
      frame_tick_reg <= 1'b0;
    end else begin
      dig_idx_reg    <= dig_idx_next;
      shadow_op_reg  <= shadow_op_next;
      shadow_a_reg   <= shadow_a_next;
      shadow_b_reg   <= shadow_b_next;
      shadow_res_reg <= shadow_res_next;
      anodo_reg      <= anodo_next;
      digit_reg      <= digit_next;
      frame_tick_reg <= frame_edge;
    end
  end

  assign anodo      = anodo_reg;
  assign digit      = digit_reg;
  assign dig_idx    = dig_idx_reg;
  assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_disp_scan_mux.sv
// Self-checking bench for disp_scan_mux: directed literal checks plus randomized run against a cycle-count model.
module tb_disp_scan_mux;

  localparam int ND  = 8;
  localparam int DW  = 8;
  localparam int DIV = 4;
  localparam int FRAME = ND * DIV;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [3:0]    op = '0;
  logic [DW-1:0] A = '0, B = '0, res = '0;
  logic [ND-1:0] anodo;
  logic [3:0]    digit;
  logic [2:0]    dig_idx;
  logic          frame_tick;

  int vectors = 0;
  int miscompares = 0;

  disp_scan_mux #(.N_DIGITS(ND), .DATA_W(DW), .REFRESH_DIV(DIV)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .A(A), .B(B), .res(res),
    .anodo(anodo), .digit(digit), .dig_idx(dig_idx), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_c = clock edges since reset release; snapshot refreshed every FRAME edges.
  int         m_c = 0;
  logic [3:0] m_op = '0;
  logic [7:0] m_a = '0, m_b = '0, m_res = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_c <= 0; m_op <= '0; m_a <= '0; m_b <= '0; m_res <= '0;
    end else begin
      m_c <= m_c + 1;
      if ((m_c + 1) % FRAME == 0) begin
        m_op <= op; m_a <= A; m_b <= B; m_res <= res;
      end
    end
  end

  function automatic void model_out(input int c, input logic [3:0] sop, input int sa, input int sb,
                                    input int sr, output logic [7:0] an, output logic [3:0] dg,
                                    output logic [2:0] ix, output logic ft);
    int idx, val, pos, nib;
    bit has, lit;
    an = 8'hFF; dg = 4'h0; ix = 3'd0; ft = 1'b0;
    if (c == 0) return;
    idx = (c / DIV) % ND;
    ix  = 3'(idx);
    ft  = (c % FRAME == 0);
    has = 0; val = 0; pos = 0;
    if (sop == 4'b1000 || sop == 4'b0100) begin
      if (idx < DW / 4) begin has = 1; val = sr; pos = idx; end
    end else if (sop == 4'b0010 || sop == 4'b0001) begin
      has = 0;
    end else if (idx < DW / 4) begin
      has = 1; val = sa; pos = idx;
    end else if (idx < DW / 2) begin
      has = 1; val = sb; pos = idx - DW / 4;
    end
    if (has) begin
      nib = (val >> (4 * pos)) & 15;
      lit = !LZB || pos == 0 || (val >> (4 * pos)) != 0;
      if (lit) begin
        an = 8'hFF ^ 8'(1 << idx);
        dg = 4'(nib);
      end
    end
  endfunction

  always @(negedge clk) begin
    logic [7:0] e_an; logic [3:0] e_dg; logic [2:0] e_ix; logic e_ft;
    model_out(m_c, m_op, int'(m_a), int'(m_b), int'(m_res), e_an, e_dg, e_ix, e_ft);
    chk("model.anodo", 32'(anodo), 32'(e_an));
    chk("model.digit", 32'(digit), 32'(e_dg));
    chk("model.dig_idx", 32'(dig_idx), 32'(e_ix));
    chk("model.frame_tick", 32'(frame_tick), 32'(e_ft));
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
  endtask

  logic [7:0] t_an [ND];
  logic [3:0] t_dg [ND];

  // Entry at edge count = FRAME (first snapshot visible); walks all eight slots.
  task automatic frame_check(input string name);
    for (int s = 0; s < ND; s++) begin
      chk({name, ".anodo"}, 32'(anodo), 32'(t_an[s]));
      chk({name, ".digit"}, 32'(digit), 32'(t_dg[s]));
      chk({name, ".idx"}, 32'(dig_idx), s);
      step(DIV);
    end
  endtask

  initial begin
    int ticks;
    int rv;
    logic [3:0] ops [8];
    ops = '{4'h0, 4'h8, 4'h4, 4'h2, 4'h1, 4'hC, 4'h3, 4'hF};

    step(1);
    chk("reset.anodo", 32'(anodo), 32'hFF);
    chk("reset.digit", 32'(digit), 0);
    chk("reset.frame_tick", 32'(frame_tick), 0);

    // Operands display
    op = 4'h0; A = 8'h3C; B = 8'hA5;
    do_reset(); step(FRAME);
    chk("ops.frame_tick", 32'(frame_tick), 1);
    t_an = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    t_dg = '{4'hC, 4'h3, 4'h5, 4'hA, 4'h0, 4'h0, 4'h0, 4'h0};
    frame_check("operands");
    op = 4'hC; do_reset(); step(FRAME);
    frame_check("multihot");

    // Result modes
    res = 8'h7E; op = 4'b1000;
    t_an = '{8'hFE, 8'hFD, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    t_dg = '{4'hE, 4'h7, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    do_reset(); step(FRAME); frame_check("res1000");
    op = 4'b0100; do_reset(); step(FRAME); frame_check("res0100");

    // Blank modes
    t_an = '{default: 8'hFF};
    t_dg = '{default: 4'h0};
    op = 4'b0010; do_reset(); step(FRAME); frame_check("blk0010");
    op = 4'b0001; do_reset(); step(FRAME); frame_check("blk0001");

    // Leading zero handling
    op = 4'h0; A = 8'h05; B = 8'h00;
    if (LZB) t_an = '{8'hFE, 8'hFF, 8'hFB, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    else     t_an = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    t_dg = '{4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    do_reset(); step(FRAME); frame_check("lzb");

    // Mid-frame input change is held off until the next frame
    A = 8'h11; B = 8'h00;
    do_reset(); step(FRAME + DIV);
    A = 8'h22;
    ticks = 0;
    for (int c = FRAME + DIV + 1; c <= 2 * FRAME; c++) begin
      step(1);
      if (frame_tick) ticks++;
      if (c == FRAME + DIV + 1) begin
        chk("hold.anodo", 32'(anodo), 32'hFD);
        chk("hold.digit", 32'(digit), 1);
      end
    end
    chk("hold.next_digit", 32'(digit), 2);
    chk("hold.next_anodo", 32'(anodo), 32'hFE);
    chk("hold.ticks", ticks, 1);

    // Reset mid-scan at slot 5
    A = 8'h3C; B = 8'hA5;
    do_reset(); step(FRAME + 5 * DIV + 2);
    chk("midrst.idx_before", 32'(dig_idx), 5);
    reset_n = 1'b0;
    #1;
    chk("midrst.anodo_async", 32'(anodo), 32'hFF);
    chk("midrst.idx_async", 32'(dig_idx), 0);
    step(1);
    chk("midrst.digit", 32'(digit), 0);
    chk("midrst.frame_tick", 32'(frame_tick), 0);
    reset_n = 1'b1;
    step(1);
    chk("midrst.restart_anodo", 32'(anodo), 32'hFE);
    chk("midrst.restart_digit", 32'(digit), 0);

    // Randomized run
    for (int i = 0; i < 4000; i++) begin
      step(1);
      if ($urandom_range(0, 7) == 0) begin
        op = ops[$urandom_range(0, 7)];
        rv = int'($urandom_range(0, 3));
        A   = (rv == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
        B   = (rv == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
        res = (rv == 2) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
      end
      if (reset_n && $urandom_range(0, 499) == 0) reset_n = 1'b0;
      else if (!reset_n && $urandom_range(0, 2) == 0) reset_n = 1'b1;
    end
    reset_n = 1'b1;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
